// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The optional subtract mode is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single 1-bit full-adder cell time-shared by the serial adder controller.
// Purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add a sub input selecting a - b.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_co;

  // Subtraction folds into the load: a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub | cin;
`else
    b_load = b;
    c_load = cin;
`endif
  end

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = c_load;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        // Counter holds at LAST on exit.
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8.
// Exercises sub mode when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, borrow as a comparison.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mc, input logic ms,
                       output logic [W-1:0] rs, output logic rc);
    int unsigned t;
    if (ms) begin
      t  = (int'(ma) - int'(mb)) & 32'hFF;
      rs = t[W-1:0];
      rc = (ma >= mb);
    end else begin
      t  = int'(ma) + int'(mb) + int'(mc);
      rs = t[W-1:0];
      rc = t[W];
    end
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ta,
                       input logic [W-1:0] tb_, input logic tc,
                       input logic ts, input logic [W-1:0] es,
                       input logic ec);
    int nb;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub_i = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom;
    nb = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    check({nm, "_busy_cycles"}, nb, W);
    check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rc, ec, rs_;
    int ndone;
    int nb;
    bit seen;

    checks = 0;
    failures = 0;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            1'b0, vecs[i].esum, vecs[i].ecout);

    // start re-asserted during RUN must be ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1; end
      if (i == 3) start = 1'b0;
      if (done) begin
        ndone++;
        check("ign_sum", 32'(sum), 32'h02);
        check("ign_cout", 32'(cout), 32'd0);
      end
      check("ign_no_restart", 32'(busy && i >= W), 32'd0);
      @(negedge clk);
    end
    check("ign_done_count", ndone, 1);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("b2b_first_done", 32'(seen), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h33);
    @(negedge clk);
    start = 1'b0;
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_old_visible", 32'(sum), 32'h33);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) nb++;
        if (busy && sum !== 8'h33) check("b2b_hold_run", 32'(sum), 32'h33);
        @(negedge clk);
      end
    end
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_second_busy", nb, W);
    check("b2b_second_sum", 32'(sum), 32'h30);

    // Reset during the 4th RUN cycle discards everything.
    @(negedge clk);
    a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    do_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
`ifdef SERIAL_ADDER_SUB_EN
      rs_ = $urandom;
`else
      rs_ = 1'b0;
`endif
      model(ra, rb, rc, rs_, es, ec);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs_, es, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It sequences one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- A carry flip-flop links successive bits.
- Trades area for latency. It provides the multi-bit add for small datapaths that contain only a single full-adder cell.
- Uses a start/busy/done handshake toward the issuing logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal values are 2 to 32.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an add. Sampled only in IDLE or DONE.
- a  in  WIDTH  operand A. Captured on an accepted start.
- b  in  WIDTH  operand B. Captured on an accepted start.
- cin  in  1  carry-in. Captured on an accepted start.
- busy  out  1  high while an add is in progress (RUN state).
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result register. Held until the next completion.
- cout  out  1  final carry-out. Held with sum.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flip-flop and bit counter are cleared. Reset applies from any state, including mid-RUN; the partial result is discarded and sum/cout read 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 loads a and b into shift registers, loads cin into the carry flip-flop and sets count=0.
  - Next state is RUN, and busy=1 from the next cycle.
- RUN (one bit per cycle):
  - The FA cell computes s and c from the LSBs of the A and B shift registers and the carry flip-flop.
  - A and B shift right. s shifts into the MSB of the partial-sum register. carry <= c, and count increments.
  - On the cycle where count==WIDTH-1, the final partial sum is transferred to sum and the final c to cout. Next state is DONE.
  - start is ignored throughout RUN, with no queuing. a, b and cin may change freely.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 in this cycle is accepted identically to IDLE, giving back-to-back operation. Otherwise the next state is IDLE.
- Latency: start sampled at edge T, then busy high for edges T+1 to T+WIDTH, then done high for the cycle following edge T+WIDTH.
  - Throughput is one add per WIDTH+1 cycles.
- sum and cout change only at completion and are stable during RUN. The previous result stays readable while a new add runs.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag is produced.
- The counter is $clog2(WIDTH) bits wide and saturates at exit, with no wrap-around into a new run.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on an accepted start.
  - sub=1 inverts B bits into the cell and forces the initial carry to 1, ignoring cin. The result is a-b; cout=1 means no borrow.
  - sub=0 behaves exactly as the base add.
- Undefined: no sub port; add-only behaviour.

Decomposition:
- Shared package/include serial_adder_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH constant.
- One sub-module, fa_cell: purely combinational 1-bit full adder (s = a^b^c; co = ab | c(a^b)). Instantiated once inside the controller.
- Everything else (FSM, shift registers, counter) stays in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulse -> busy high 8 cycles, then done for 1 cycle, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start accepted with a=8'h01, b=8'h01; start re-asserted with new operands during RUN -> ignored. Result sum=8'h02, and exactly one done pulse.
- start held high through the DONE cycle with a=8'h10, b=8'h20 -> second add begins immediately. sum=8'h30 after a further WIDTH+1 cycles, and the first result is visible in between.
- rst asserted at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0. A subsequent start with a=8'h03, b=8'h04 gives sum=8'h07.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - sub=1, a=8'h00, b=8'h01 -> sum=8'hFF, cout=0.
